// File: rtl/fmc120_cpld_spi_read_seq_if.sv
// Port bundle between the read sequencer and the shared I2C byte engine.
// Handshake: the sequencer pulses start for one cycle with datatx/nack/stopbit
// already stable; the engine holds running high while busy, and datarx is valid
// once running falls. The sequencer treats running low (after its settle
// window) as transaction complete.
interface fmc120_cpld_spi_read_seq_if;
   logic        start;
   logic        stopbit;
   logic [3:0]  nack;
   logic [31:0] datatx;
   logic        running;
   logic [31:0] datarx;

   modport master (
      output start, stopbit, nack, datatx,
      input  running, datarx
   );

   modport slave (
      input  start, stopbit, nack, datatx,
      output running, datarx
   );
endinterface

// File: rtl/fmc120_cpld_spi_read_seq.sv
// FMC120 CPLD I2C-to-SPI bridge read sequencer: switch steering, SPI address
// load, bridge read action and result readback through the shared I2C engine.
module fmc120_cpld_spi_read_seq #(
   parameter int TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        sreset,
   input  logic [31:0] devcmd,
   input  logic        stb_devcmd,
   input  logic [7:0]  i2cswlocation,
   fmc120_cpld_spi_read_seq_if.master eng,
   output logic        busy,
   output logic [23:0] rddata,
   output logic        rdvalid,
   output logic        rderr,
   output logic [3:0]  dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_SWITCH = 4'd1,
      S_SPI8   = 4'd2,
      S_SPI7   = 4'd3,
      S_SPI0   = 4'd4,
      S_RDPTR  = 4'd5,
      S_RDDATA = 4'd6,
      S_DONE   = 4'd7,
      S_ERR    = 4'd8
   } state_t;

   localparam logic [6:0]  SWITCH_ADDR = 7'h74;
   localparam logic [6:0]  BRIDGE_ADDR = 7'h1c;
   localparam logic [15:0] TO_LIMIT    = 16'(TIMEOUT);

   state_t      state, state_nx;
   logic [15:0] scnt;
   logic [3:0]  dev_q;
   logic [7:0]  addr_hi_q, addr_lo_q;
   logic        busy_q, busy_nx;
   logic [23:0] rddata_q;
   logic [31:0] datatx_q, tx_nx;
   logic [3:0]  nack_q, nack_nx;
   logic        stop_q, stop_nx;

   logic [3:0]  src_dev;
   logic [7:0]  src_hi, src_lo;
   logic [7:0]  sw_sel, action;
   logic        cmd_ok, spi_dev, len2, xfer, adv;

   // While idle, decode straight from the incoming command so the first
   // transaction's payload can be registered on the capture edge.
   always_comb begin
      src_dev = (state == S_IDLE) ? devcmd[31:28] : dev_q;
      src_hi  = (state == S_IDLE) ? devcmd[23:16] : addr_hi_q;
      src_lo  = (state == S_IDLE) ? devcmd[15:8]  : addr_lo_q;
      sw_sel  = src_dev[3] ? 8'h04 : 8'h02;
      spi_dev = (src_dev[2:0] != 3'd0);
      len2    = (src_dev[2:0] == 3'd2);
      cmd_ok  = devcmd[24] && (devcmd[30:28] < 3'd5);
      case (src_dev[2:0])
         3'd1:    action = 8'h01;
         3'd2:    action = 8'h02;
         3'd3:    action = 8'h04;
         3'd4:    action = 8'h08;
         default: action = 8'h00;
      endcase
   end

   assign xfer = (state == S_SWITCH) || (state == S_SPI8) || (state == S_SPI7) ||
                 (state == S_SPI0) || (state == S_RDPTR) || (state == S_RDDATA);
   assign adv  = (scnt >= 16'd8) && !eng.running;

   always_comb begin
      state_nx = state;
      busy_nx  = busy_q;
      case (state)
         S_IDLE: begin
            if (stb_devcmd) begin
               if (!cmd_ok) begin
                  state_nx = S_ERR;
               end else begin
                  busy_nx = 1'b1;
                  if (i2cswlocation != sw_sel) state_nx = S_SWITCH;
                  else if (spi_dev)            state_nx = S_SPI8;
                  else                         state_nx = S_RDPTR;
               end
            end
         end
         S_SWITCH: if (adv) state_nx = spi_dev ? S_SPI8 : S_RDPTR;
         S_SPI8:   if (adv) state_nx = S_SPI7;
         S_SPI7:   if (adv) state_nx = S_SPI0;
         S_SPI0:   if (adv) state_nx = S_RDPTR;
         S_RDPTR:  if (adv) state_nx = S_RDDATA;
         S_RDDATA: if (adv) state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         S_ERR:    state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (xfer && (scnt == TO_LIMIT)) state_nx = S_ERR;
      if (state_nx == S_IDLE) busy_nx = 1'b0;

      // Payload for the state being entered; held in registers for its duration.
      tx_nx   = 32'h0;
      nack_nx = 4'd0;
      stop_nx = 1'b0;
      case (state_nx)
         S_SWITCH: begin
            tx_nx = {SWITCH_ADDR, 1'b0, sw_sel, 16'h0000}; nack_nx = 4'd2; stop_nx = 1'b1;
         end
         S_SPI8: begin
            tx_nx = {BRIDGE_ADDR, 1'b0, 8'h08, src_hi, 8'h00}; nack_nx = 4'd3; stop_nx = 1'b1;
         end
         S_SPI7: begin
            tx_nx = {BRIDGE_ADDR, 1'b0, 8'h07, src_lo, 8'h00}; nack_nx = 4'd3; stop_nx = 1'b1;
         end
         S_SPI0: begin
            tx_nx = {BRIDGE_ADDR, 1'b0, 8'h00, action | 8'h80, 8'h00}; nack_nx = 4'd3; stop_nx = 1'b1;
         end
         S_RDPTR: begin
            tx_nx   = spi_dev ? {BRIDGE_ADDR, 1'b0, 8'h06, 16'h0000}
                              : {BRIDGE_ADDR, 1'b0, src_hi, 16'h0000};
            nack_nx = 4'd2;
            stop_nx = 1'b1;
         end
         S_RDDATA: begin
            tx_nx = {BRIDGE_ADDR, 1'b1, 24'h000000}; nack_nx = len2 ? 4'd2 : 4'd1; stop_nx = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge sreset) begin
      if (sreset) begin
         state     <= S_IDLE;
         scnt      <= 16'd0;
         dev_q     <= 4'd0;
         addr_hi_q <= 8'h00;
         addr_lo_q <= 8'h00;
         busy_q    <= 1'b0;
         rddata_q  <= 24'h0;
         datatx_q  <= 32'h0;
         nack_q    <= 4'd0;
         stop_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         busy_q   <= busy_nx;
         datatx_q <= tx_nx;
         nack_q   <= nack_nx;
         stop_q   <= stop_nx;
         if (state_nx != state)    scnt <= 16'd0;
         else if (state != S_IDLE) scnt <= scnt + 16'd1;
         if ((state == S_IDLE) && stb_devcmd && cmd_ok) begin
            dev_q     <= devcmd[31:28];
            addr_hi_q <= devcmd[23:16];
            addr_lo_q <= devcmd[15:8];
         end
         if ((state == S_RDDATA) && (state_nx == S_DONE))
            rddata_q <= len2 ? {8'h00, eng.datarx[15:0]} : {16'h0000, eng.datarx[7:0]};
      end
   end

   assign eng.start   = xfer && (scnt == 16'd2);
   assign eng.datatx  = datatx_q;
   assign eng.nack    = nack_q;
   assign eng.stopbit = stop_q;
   assign busy        = busy_q;
   assign rddata      = rddata_q;
   assign rdvalid     = (state == S_DONE);
   assign rderr       = (state == S_ERR);
   assign dbg_state   = state;

endmodule
